uart_tx_arb: RTL and testbench



---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_arb_if.sv | 21 ++
 rtl/rr_pick.sv | 24 ++
 rtl/uart_tx_arb.sv | 76 +++++++
 tb/tb_uart_tx_arb.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART arbiter and dispatcher blocks.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam logic [1:0] ST_ARB = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;
  typedef logic [BYTE_W-1:0] byte_t;
  function automatic int owner_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester-side and serializer-side signals of the UART TX arbiter.
interface uart_tx_arb_if import uart_pkg::*; #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] i_ReqValid;
  logic [BYTE_W*NUM_REQ-1:0] i_ReqByte;
  logic [NUM_REQ-1:0] i_ReqLast;
  logic [NUM_REQ-1:0] o_ReqReady;
  logic o_TxValid;
  logic [BYTE_W-1:0] o_TxByte;
  logic i_TxDone;
  logic o_Busy;
  logic [owner_w(NUM_REQ)-1:0] o_Owner;
  logic o_LockTimeout;
  modport master (
    input i_ReqValid, i_ReqByte, i_ReqLast, i_TxDone,
    output o_ReqReady, o_TxValid, o_TxByte, o_Busy, o_Owner, o_LockTimeout
  );
  modport slave (
    output i_ReqValid, i_ReqByte, i_ReqLast, i_TxDone,
    input o_ReqReady, o_TxValid, o_TxByte, o_Busy, o_Owner, o_LockTimeout
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker, first set request at or after ptr.
module rr_pick import uart_pkg::*; #(
  parameter int N = 4,
  localparam int IW = owner_w(N)
) (
  input logic [N-1:0] req,
  input logic [IW-1:0] ptr,
  output logic found,
  output logic [IW-1:0] idx
);
  function automatic logic [IW-1:0] slot(input logic [IW-1:0] p, input int i);
    return IW'((int'(p) + i) % N);
  endfunction
  // scanned farthest-first so the nearest hit to ptr is the one that sticks
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[slot(ptr, i)]) begin
        found = 1'b1;
        idx = slot(ptr, i);
      end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte
// producers, with an optional per-message lock and a stall timeout on that lock.
module uart_tx_arb import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input logic i_SysClock,
  input logic i_Reset,
  uart_tx_arb_if.master bus
);
  localparam int OW = owner_w(NUM_REQ);
  localparam int CW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  logic [1:0] state;
  logic [OW-1:0] rr_ptr, owner, pick_idx, cand, nxt;
  logic lock, pick_found, cand_ok, grant, stall, lock_to;
  logic [CW-1:0] lock_cnt;
  byte_t tx_byte;
  logic [NUM_REQ-1:0][BYTE_W-1:0] bytes;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(bus.i_ReqValid),
    .ptr(rr_ptr),
    .found(pick_found),
    .idx(pick_idx)
  );
  assign bytes = bus.i_ReqByte;
  assign cand = lock ? owner : pick_idx;
  assign cand_ok = lock ? bus.i_ReqValid[owner] : pick_found;
  assign grant = state == ST_ARB && bus.i_TxDone && cand_ok;
  assign stall = state == ST_ARB && lock && !bus.i_ReqValid[owner] && LOCK_TIMEOUT != 0;
  assign nxt = owner == OW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
  assign bus.o_ReqReady = grant ? NUM_REQ'(1) << cand : '0;
  assign bus.o_TxValid = state == ST_ISSUE;
  assign bus.o_TxByte = tx_byte;
  assign bus.o_Busy = state != ST_ARB;
  assign bus.o_Owner = owner;
  assign bus.o_LockTimeout = lock_to;
  // tx_byte is only written in ARB, so it stays put for the whole serializer frame
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      state <= ST_ARB;
      rr_ptr <= '0;
      owner <= '0;
      lock <= 1'b0;
      tx_byte <= '0;
      lock_cnt <= '0;
      lock_to <= 1'b0;
    end else begin
      lock_to <= 1'b0;
      case (state)
        ST_ARB:
          if (grant) begin
            tx_byte <= bytes[cand];
            owner <= cand;
            lock <= ~bus.i_ReqLast[cand];
            lock_cnt <= '0;
            state <= ST_ISSUE;
          end else if (stall) begin
            if (lock_cnt == CW'(LOCK_TIMEOUT - 1)) begin
              lock <= 1'b0;
              rr_ptr <= nxt;
              lock_cnt <= '0;
              lock_to <= 1'b1;
            end else
              lock_cnt <= lock_cnt + 1'b1;
          end
        ST_ISSUE: state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: state <= bus.i_TxDone ? ST_WAIT_BUSY : ST_WAIT_DONE;
        default:
          if (bus.i_TxDone) begin
            state <= ST_ARB;
            rr_ptr <= lock ? rr_ptr : nxt;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized bench for uart_tx_arb against a cycle-level
// behavioural model plus a simple serializer model driving i_TxDone.
module tb_uart_tx_arb;
  localparam int N = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arb_if #(.NUM_REQ(N)) bus ();
  uart_tx_arb #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (.i_SysClock(clk), .i_Reset(rst), .bus(bus));
  int errors = 0, checks = 0, cyc = 0;
  bit run = 0, force_busy = 0, drop_en = 0, busy_prev = 0;
  logic [8:0] rq [N][$];
  int ser_cnt = 0, ser_len = 4;
  logic [7:0] act_bytes[$], exp_bytes[$];
  int act_grants[$], exp_grants[$];
  int g_cyc = -1, v_cyc = -1, arb_entry = 0, to_delay = -1, to_cnt = 0;
  bit m_idle = 1, m_low = 0, m_lock = 0, m_to = 0;
  int m_age = 0, m_owner = 0, m_ptr = 0, m_stall = 0;
  logic [7:0] m_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: picks the winner by scanning from the pointer, then tracks one frame as
  // "issue one cycle, wait for done to drop, wait for done to come back".
  always @(negedge clk) begin
    logic [N-1:0] er;
    int c;
    bit ok;
    cyc++;
    c = m_owner;
    ok = 0;
    if (m_lock) ok = bus.i_ReqValid[m_owner];
    else
      for (int i = 0; i < N; i++)
        if (!ok && bus.i_ReqValid[(m_ptr + i) % N]) begin
          ok = 1;
          c = (m_ptr + i) % N;
        end
    er = (m_idle && bus.i_TxDone && ok) ? N'(1 << c) : '0;
    if (run) begin
      check("ready", bus.o_ReqReady, er);
      check("tx_valid", bus.o_TxValid, !m_idle && m_age == 1);
      check("tx_byte", bus.o_TxByte, m_byte);
      check("busy", bus.o_Busy, !m_idle);
      check("owner", bus.o_Owner, m_owner);
      check("lock_timeout", bus.o_LockTimeout, m_to);
      if (bus.o_ReqReady != 0) begin
        act_grants.push_back($clog2(bus.o_ReqReady));
        g_cyc = cyc;
      end
      if (bus.o_TxValid) v_cyc = cyc;
      if (busy_prev && !bus.o_Busy) arb_entry = cyc;
      if (bus.o_LockTimeout) begin
        to_cnt++;
        to_delay = cyc - arb_entry;
      end
      busy_prev = bus.o_Busy;
    end
    m_to = 0;
    if (rst) begin
      m_idle = 1; m_low = 0; m_lock = 0; m_age = 0;
      m_owner = 0; m_ptr = 0; m_stall = 0; m_byte = 8'h00;
    end else if (m_idle) begin
      if (er != 0) begin
        m_idle = 0; m_age = 1; m_low = 0; m_owner = c; m_stall = 0;
        m_byte = bus.i_ReqByte[8*c +: 8];
        m_lock = !bus.i_ReqLast[c];
        exp_grants.push_back(c);
        exp_bytes.push_back(m_byte);
      end else if (m_lock && !bus.i_ReqValid[m_owner]) begin
        m_stall++;
        if (m_stall == TO) begin
          m_lock = 0; m_stall = 0; m_to = 1;
          m_ptr = (m_owner + 1) % N;
        end
      end
    end else begin
      if (m_age >= 2) begin
        if (!m_low) m_low = !bus.i_TxDone;
        else if (bus.i_TxDone) begin
          m_idle = 1;
          if (!m_lock) m_ptr = (m_owner + 1) % N;
        end
      end
      m_age++;
    end
  end

  task automatic drive();
    logic [8:0] h;
    for (int k = 0; k < N; k++) begin
      h = rq[k].size() > 0 ? rq[k][0] : {1'b1, 8'($urandom)};
      bus.i_ReqValid[k] = rq[k].size() > 0 && !(drop_en && $urandom_range(0, 15) == 0);
      bus.i_ReqByte[8*k +: 8] = h[7:0];
      bus.i_ReqLast[k] = h[8];
    end
  endtask

  task automatic step();
    logic v, r;
    logic [7:0] b;
    logic [N-1:0] rdy;
    @(negedge clk);
    v = bus.o_TxValid; b = bus.o_TxByte; rdy = bus.o_ReqReady; r = rst;
    @(posedge clk);
    #1;
    if (r) ser_cnt = 0;
    else if (v && ser_cnt == 0) begin
      ser_cnt = ser_len;
      act_bytes.push_back(b);
    end else if (ser_cnt > 0) ser_cnt--;
    bus.i_TxDone = ser_cnt == 0 && !force_busy;
    for (int k = 0; k < N; k++)
      if (rdy[k] && !r) void'(rq[k].pop_front());
    drive();
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (rq[k].size() > 0) return 1;
    return 0;
  endfunction

  task automatic settle();
    int n = 0;
    drive();
    while (n < 2000 && (pending() || bus.o_Busy)) begin
      step();
      n++;
    end
    check("settle_in_budget", n < 2000, 1);
  endtask

  task automatic push(input int k, input logic [7:0] b, input bit last);
    rq[k].push_back({last, b});
  endtask

  task automatic clear_logs();
    act_bytes.delete(); exp_bytes.delete(); act_grants.delete(); exp_grants.delete();
    to_cnt = 0; to_delay = -1;
  endtask

  function automatic int gi(input int i);
    return i < act_grants.size() ? act_grants[i] : -1;
  endfunction

  function automatic int bi(input int i);
    return i < act_bytes.size() ? int'(act_bytes[i]) : -1;
  endfunction

  task automatic expect_run(input string name, input int n, input int gs[4], input int bs[4]);
    check({name, "_count"}, act_grants.size(), n);
    check({name, "_model_count"}, exp_grants.size(), n);
    for (int i = 0; i < n; i++) begin
      check({name, "_grant"}, gi(i), gs[i]);
      check({name, "_byte"}, bi(i), bs[i]);
      check({name, "_model_byte"}, i < exp_bytes.size() ? int'(exp_bytes[i]) : -1, bs[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb_left, n, wait_n;
    bus.i_ReqValid = '0; bus.i_ReqByte = '0; bus.i_ReqLast = '0; bus.i_TxDone = 1'b1;
    repeat (2) step();
    run = 1;
    step();
    rst = 0;
    // single byte from requester 2, then pointer sits at 3 and wraps to 0
    clear_logs();
    push(2, 8'hA5, 1);
    settle();
    expect_run("t1", 1, '{2, 0, 0, 0}, '{8'hA5, 0, 0, 0});
    check("t1_valid_lag", v_cyc - g_cyc, 1);
    clear_logs();
    push(0, 8'h01, 1); push(3, 8'h03, 1);
    settle();
    expect_run("t1_wrap", 2, '{3, 0, 0, 0}, '{8'h03, 8'h01, 0, 0});
    // three contenders from pointer 0
    rst = 1; step(); step(); rst = 0;
    clear_logs();
    push(0, 8'h10, 1); push(0, 8'h20, 1); push(1, 8'h30, 1); push(3, 8'h40, 1);
    settle();
    expect_run("t2", 4, '{0, 1, 3, 0}, '{8'h10, 8'h30, 8'h40, 8'h20});
    // locked three-byte message is not interleaved with requester 0
    clear_logs();
    push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1); push(0, 8'h44, 1);
    settle();
    expect_run("t3", 4, '{1, 1, 1, 0}, '{8'h11, 8'h22, 8'h33, 8'h44});
    // owner goes silent with the lock held
    clear_logs();
    push(1, 8'h55, 0); push(2, 8'h66, 1);
    settle();
    expect_run("t4", 2, '{1, 2, 0, 0}, '{8'h55, 8'h66, 0, 0});
    check("t4_timeout_pulses", to_cnt, 1);
    check("t4_timeout_delay", to_delay, TO);
    // reset while waiting for the serializer to finish a locked byte
    clear_logs();
    push(3, 8'h77, 0);
    drive();
    wait_n = 0;
    while (!bus.o_TxValid && wait_n < 50) begin step(); wait_n++; end
    check("t5_issue_seen", bus.o_TxValid, 1);
    step(); step();
    rst = 1;
    step();
    check("t5_tx_valid", bus.o_TxValid, 0);
    check("t5_tx_byte", bus.o_TxByte, 8'h00);
    check("t5_busy", bus.o_Busy, 0);
    check("t5_owner", bus.o_Owner, 0);
    rst = 0;
    clear_logs();
    push(1, 8'h88, 1); push(3, 8'h99, 1);
    settle();
    expect_run("t5_after", 2, '{1, 3, 0, 0}, '{8'h88, 8'h99, 0, 0});
    check("t5_no_timeout", to_cnt, 0);
    // serializer busy from elsewhere for 100 cycles
    clear_logs();
    force_busy = 1; bus.i_TxDone = 1'b0;
    push(2, 8'hAA, 1);
    drive();
    repeat (100) step();
    check("t6_no_grant", act_grants.size(), 0);
    force_busy = 0; bus.i_TxDone = 1'b1;
    n = cyc + 1;
    settle();
    check("t6_grant_cycle", g_cyc, n);
    expect_run("t6", 1, '{2, 0, 0, 0}, '{8'hAA, 0, 0, 0});
    // random traffic with drops, partial messages and external busy bursts
    clear_logs();
    drop_en = 1;
    fb_left = 0;
    for (int t = 0; t < 4000; t++) begin
      for (int k = 0; k < N; k++)
        if (rq[k].size() == 0 && $urandom_range(0, 3) == 0) begin
          n = $urandom_range(1, 3);
          for (int j = 0; j < n; j++)
            push(k, 8'($urandom), j == n - 1 && $urandom_range(0, 7) != 0);
        end
      ser_len = $urandom_range(1, 6);
      if (!force_busy && $urandom_range(0, 199) == 0) begin
        force_busy = 1;
        fb_left = $urandom_range(5, 30);
      end
      step();
      if (force_busy) begin
        fb_left--;
        if (fb_left == 0) force_busy = 0;
      end
    end
    drop_en = 0;
    force_busy = 0;
    settle();
    check("rand_activity", exp_bytes.size() > 100, 1);
    check("rand_count", act_bytes.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size(); i++) begin
      check("rand_byte", bi(i), exp_bytes[i]);
      check("rand_grant", gi(i), exp_grants[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
